// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// One operation in flight: accept (IDLE) -> drive ALU (ISSUE) -> respond (RESP).
module alu_arbiter #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FLAG_W = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,

  input  logic              req0_valid_i,
  input  logic              req0_op_i,
  input  logic [DATA_W-1:0] req0_a_i,
  input  logic [DATA_W-1:0] req0_b_i,
  output logic              req0_ready_o,
  output logic              rsp0_valid_o,
  output logic [DATA_W-1:0] rsp0_result_o,
  output logic [FLAG_W-1:0] rsp0_flags_o,

  input  logic              req1_valid_i,
  input  logic              req1_op_i,
  input  logic [DATA_W-1:0] req1_a_i,
  input  logic [DATA_W-1:0] req1_b_i,
  output logic              req1_ready_o,
  output logic              rsp1_valid_o,
  output logic [DATA_W-1:0] rsp1_result_o,
  output logic [FLAG_W-1:0] rsp1_flags_o,

  output logic              alu_op_o,
  output logic [DATA_W-1:0] alu_operand1_o,
  output logic [DATA_W-1:0] alu_operand2_o,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [FLAG_W-1:0] alu_flags_i
);

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e              state_q, state_d;
  logic                gnt_q, gnt_d;
  logic                last_q, last_d;
  logic                op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [DATA_W-1:0]   res_q, res_d;
  logic [FLAG_W-1:0]   flg_q, flg_d;
  logic                pick;
  logic                accept;

  // Tie goes to the port that did not win last time; otherwise the lone requester.
  always_comb begin
    if (req0_valid_i && req1_valid_i) begin
      pick = ~last_q;
    end else begin
      pick = ~req0_valid_i;
    end
  end

  assign accept = (state_q == StIdle) && (req0_valid_i || req1_valid_i);

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flg_d   = flg_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = StIssue;
          gnt_d   = pick;
          last_d  = pick;
          op_d    = pick ? req1_op_i : req0_op_i;
          a_d     = pick ? req1_a_i  : req0_a_i;
          b_d     = pick ? req1_b_i  : req0_b_i;
        end
      end
      StIssue: begin
        res_d   = alu_result_i;
        flg_d   = alu_flags_i;
        state_d = StResp;
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
    end
  end

  // Ready is masked while reset is held so no handshake appears to complete.
  assign req0_ready_o   = accept && !pick && !rst_i;
  assign req1_ready_o   = accept &&  pick && !rst_i;

  assign rsp0_valid_o   = (state_q == StResp) && !gnt_q;
  assign rsp1_valid_o   = (state_q == StResp) &&  gnt_q;
  assign rsp0_result_o  = res_q;
  assign rsp1_result_o  = res_q;
  assign rsp0_flags_o   = flg_q;
  assign rsp1_flags_o   = flg_q;

  assign alu_op_o       = op_q;
  assign alu_operand1_o = a_q;
  assign alu_operand2_o = b_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: behavioural ALU plus a cycle-scheduled reference model
// compared against every output each cycle, with directed and random stimulus.
module tb_alu_arbiter;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       req0_valid_i = 1'b0, req0_op_i = 1'b0;
  logic [7:0] req0_a_i = '0, req0_b_i = '0;
  logic       req1_valid_i = 1'b0, req1_op_i = 1'b0;
  logic [7:0] req1_a_i = '0, req1_b_i = '0;
  logic       req0_ready_o, rsp0_valid_o, req1_ready_o, rsp1_valid_o;
  logic [7:0] rsp0_result_o, rsp1_result_o;
  logic [1:0] rsp0_flags_o, rsp1_flags_o;
  logic       alu_op_o;
  logic [7:0] alu_operand1_o, alu_operand2_o, alu_result_i;
  logic [1:0] alu_flags_i;

  always #5 clk_i = ~clk_i;

  alu_arbiter #(.DATA_W(8), .FLAG_W(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req0_valid_i(req0_valid_i), .req0_op_i(req0_op_i), .req0_a_i(req0_a_i),
    .req0_b_i(req0_b_i), .req0_ready_o(req0_ready_o), .rsp0_valid_o(rsp0_valid_o),
    .rsp0_result_o(rsp0_result_o), .rsp0_flags_o(rsp0_flags_o),
    .req1_valid_i(req1_valid_i), .req1_op_i(req1_op_i), .req1_a_i(req1_a_i),
    .req1_b_i(req1_b_i), .req1_ready_o(req1_ready_o), .rsp1_valid_o(rsp1_valid_o),
    .rsp1_result_o(rsp1_result_o), .rsp1_flags_o(rsp1_flags_o),
    .alu_op_o(alu_op_o), .alu_operand1_o(alu_operand1_o), .alu_operand2_o(alu_operand2_o),
    .alu_result_i(alu_result_i), .alu_flags_i(alu_flags_i)
  );

  // ALU: op 0 = add, op 1 = subtract; flags = {signed overflow, 0}.
  function automatic logic [9:0] alu_fn(input logic op, input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    logic       ovf;
    if (!op) begin
      r   = a + b;
      ovf = (a[7] == b[7]) && (r[7] != a[7]);
    end else begin
      r   = a - b;
      ovf = (a[7] != b[7]) && (r[7] != a[7]);
    end
    return {ovf, 1'b0, r};
  endfunction

  assign {alu_flags_i, alu_result_i} = alu_fn(alu_op_o, alu_operand1_o, alu_operand2_o);

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: an accept at cycle c puts operands on the ALU from c+1,
  // pulses the owner's response at c+2 and frees the arbiter at c+3.
  int         cyc = 0, free_at = 0, apply_at = -10, resp_at = -10, resp_port = 0;
  bit         last_g = 1'b1;
  logic       m_op = 1'b0, p_op = 1'b0;
  logic [7:0] m_a = '0, m_b = '0, m_res = '0, p_a = '0, p_b = '0, p_res = '0;
  logic [1:0] m_flg = '0, p_flg = '0;

  task automatic model_reset();
    m_op = 1'b0; m_a = '0; m_b = '0; m_res = '0; m_flg = '0;
    free_at = cyc; apply_at = -10; resp_at = -10; last_g = 1'b1;
  endtask

  task automatic step();
    int g;
    if (cyc == apply_at) begin
      m_op = p_op; m_a = p_a; m_b = p_b;
    end
    if (cyc == resp_at) begin
      m_res = p_res; m_flg = p_flg;
    end
    g = -1;
    if (cyc >= free_at) begin
      if (req0_valid_i && req1_valid_i) g = last_g ? 0 : 1;
      else if (req0_valid_i) g = 0;
      else if (req1_valid_i) g = 1;
    end
    check("ready0", 32'(req0_ready_o), 32'(g == 0));
    check("ready1", 32'(req1_ready_o), 32'(g == 1));
    check("rsp0_valid", 32'(rsp0_valid_o), 32'(cyc == resp_at && resp_port == 0));
    check("rsp1_valid", 32'(rsp1_valid_o), 32'(cyc == resp_at && resp_port == 1));
    check("rsp0_result", 32'(rsp0_result_o), 32'(m_res));
    check("rsp1_result", 32'(rsp1_result_o), 32'(m_res));
    check("rsp0_flags", 32'(rsp0_flags_o), 32'(m_flg));
    check("rsp1_flags", 32'(rsp1_flags_o), 32'(m_flg));
    check("alu_op", 32'(alu_op_o), 32'(m_op));
    check("alu_operand1", 32'(alu_operand1_o), 32'(m_a));
    check("alu_operand2", 32'(alu_operand2_o), 32'(m_b));
    if (g >= 0) begin
      if (g == 0) begin
        p_op = req0_op_i; p_a = req0_a_i; p_b = req0_b_i;
      end else begin
        p_op = req1_op_i; p_a = req1_a_i; p_b = req1_b_i;
      end
      {p_flg, p_res} = alu_fn(p_op, p_a, p_b);
      apply_at  = cyc + 1;
      resp_at   = cyc + 2;
      resp_port = g;
      free_at   = cyc + 3;
      last_g    = (g == 1);
    end
    cyc++;
  endtask

  task automatic drive(input logic v0, input logic o0, input logic [7:0] a0, input logic [7:0] b0,
                       input logic v1, input logic o1, input logic [7:0] a1, input logic [7:0] b1);
    @(negedge clk_i);
    req0_valid_i = v0; req0_op_i = o0; req0_a_i = a0; req0_b_i = b0;
    req1_valid_i = v1; req1_op_i = o1; req1_a_i = a1; req1_b_i = b1;
    #1 step();
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  // Asserts reset mid-cycle with the given valids, checks outputs clear at once,
  // then releases it on the next falling edge and models that cycle.
  task automatic apply_reset(input logic v0, input logic v1);
    @(negedge clk_i);
    req0_valid_i = v0; req1_valid_i = v1;
    #2 rst_i = 1'b1;
    #1;
    check("rst_ready0", 32'(req0_ready_o), 32'd0);
    check("rst_ready1", 32'(req1_ready_o), 32'd0);
    check("rst_rsp0", 32'(rsp0_valid_o), 32'd0);
    check("rst_rsp1", 32'(rsp1_valid_o), 32'd0);
    check("rst_alu_op", 32'(alu_op_o), 32'd0);
    check("rst_alu_a", 32'(alu_operand1_o), 32'd0);
    check("rst_alu_b", 32'(alu_operand2_o), 32'd0);
    check("rst_result", 32'(rsp0_result_o), 32'd0);
    check("rst_flags", 32'(rsp1_flags_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    model_reset();
    #1 step();
  endtask

  initial begin
    apply_reset(1'b1, 1'b1);

    // Both valid continuously from reset: grants alternate 0,1,0,1 every 3 cycles.
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, 8'(i), 8'h01, 1'b1, 1'b0, 8'(8'h40 + i), 8'h02);
      if (i % 3 == 0) begin
        check("t3_rdy0", 32'(req0_ready_o), 32'(i % 6 == 0));
        check("t3_rdy1", 32'(req1_ready_o), 32'(i % 6 == 3));
      end
    end
    idle(3);

    // Port 0 alone: 5 + 3.
    drive(1'b1, 1'b0, 8'h05, 8'h03, 1'b0, 1'b0, 8'h00, 8'h00);
    check("t1_ready", 32'(req0_ready_o), 32'd1);
    idle(1);
    check("t1_early", 32'(rsp0_valid_o), 32'd0);
    idle(1);
    check("t1_valid", 32'(rsp0_valid_o), 32'd1);
    check("t1_other", 32'(rsp1_valid_o), 32'd0);
    check("t1_result", 32'(rsp0_result_o), 32'h08);
    check("t1_flags", 32'(rsp0_flags_o), 32'h0);

    // Port 1 overflow: 0x7F + 1.
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h7F, 8'h01);
    idle(2);
    check("t2_valid", 32'(rsp1_valid_o), 32'd1);
    check("t2_result", 32'(rsp1_result_o), 32'h80);
    check("t2_flags", 32'(rsp1_flags_o), 32'h2);

    // Port 0 waits through a port-1 op, then is accepted with its own operands.
    idle(1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h10, 8'h01);
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 8'h33, 8'h11, 1'b0, 1'b0, 8'h00, 8'h00);
      check("t4_ready", 32'(req0_ready_o), 32'(i == 2));
    end
    idle(1);
    check("t4_alu_op", 32'(alu_op_o), 32'd1);
    check("t4_alu_a", 32'(alu_operand1_o), 32'h33);
    check("t4_alu_b", 32'(alu_operand2_o), 32'h11);
    idle(1);
    check("t4_result", 32'(rsp0_result_o), 32'h22);

    // Wrap then back-to-back signed overflow that also wraps to zero.
    idle(1);
    drive(1'b1, 1'b0, 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(1'b1, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00);
    check("t6_res_a", 32'(rsp0_result_o), 32'h00);
    check("t6_flg_a", 32'(rsp0_flags_o), 32'h0);
    drive(1'b1, 1'b0, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h00);
    check("t6_ready", 32'(req0_ready_o), 32'd1);
    idle(2);
    check("t6_res_b", 32'(rsp0_result_o), 32'h00);
    check("t6_flg_b", 32'(rsp0_flags_o), 32'h2);

    // Reset during ISSUE: no response afterwards, port 0 wins the next tie.
    idle(1);
    drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 8'h12, 8'h34);
    apply_reset(1'b1, 1'b1);
    check("t5_no_rsp", 32'(rsp1_valid_o), 32'd0);
    drive(1'b1, 1'b0, 8'h01, 8'h02, 1'b1, 1'b0, 8'h03, 8'h04);
    check("t5_tie0", 32'(req0_ready_o), 32'd1);
    idle(3);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      drive(1'($urandom_range(0, 9) < 6), 1'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom_range(0, 9) < 6), 1'($urandom), 8'($urandom), 8'($urandom));
    end
    idle(3);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
